// File: rtl/ex_latency_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_latency_tracker_pkg
// Description : Shared EX-stage constants: per-op latencies, tag width, clog2.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_latency_tracker_pkg;

    localparam int LAT_FADD  = 7;
    localparam int LAT_FSUB  = 7;
    localparam int LAT_FMUL  = 5;
    localparam int LAT_FDIV  = 6;
    localparam int LAT_ITOF  = 6;
    localparam int LAT_FTOI  = 6;
    localparam int LAT_IMUL  = 7;
    localparam int LAT_ALU   = 0;

    localparam int TAG_W_DEF = 4;

    typedef enum logic [2:0] {
        OP_FADD = 3'd0,
        OP_FSUB = 3'd1,
        OP_FMUL = 3'd2,
        OP_FDIV = 3'd3,
        OP_ITOF = 3'd4,
        OP_FTOI = 3'd5,
        OP_IMUL = 3'd6,
        OP_ALU  = 3'd7
    } ex_op_e;

    function automatic int op_latency(input ex_op_e op);
        case (op)
            OP_FADD: return LAT_FADD;
            OP_FSUB: return LAT_FSUB;
            OP_FMUL: return LAT_FMUL;
            OP_FDIV: return LAT_FDIV;
            OP_ITOF: return LAT_ITOF;
            OP_FTOI: return LAT_FTOI;
            OP_IMUL: return LAT_IMUL;
            default: return LAT_ALU;
        endcase
    endfunction

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_latency_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_latency_tracker_if
// Description : Issue / writeback / status bundle between EX stage and tracker.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_latency_tracker_if
    import ex_latency_tracker_pkg::*;
#(
    parameter int LAT_W = 4,
    parameter int TAG_W = TAG_W_DEF,
    parameter int CNT_W = 3
);
    logic             issue_valid;
    logic [LAT_W-1:0] issue_latency;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_ready;
    logic             flush;
    logic             done_valid;
    logic [TAG_W-1:0] done_tag;
    logic             stall;
    logic             busy;
    logic [CNT_W-1:0] inflight_cnt;

    modport master (
        output issue_valid, issue_latency, issue_tag, flush,
        input  issue_ready, done_valid, done_tag, stall, busy, inflight_cnt
    );

    modport slave (
        input  issue_valid, issue_latency, issue_tag, flush,
        output issue_ready, done_valid, done_tag, stall, busy, inflight_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ex_latency_tracker_completion_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ex_completion_pipe
// Description : Completion slot shift register; slot[i] retires i cycles ahead.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_completion_pipe
    import ex_latency_tracker_pkg::*;
#(
    parameter int DEPTH = 15,
    parameter int TAG_W = TAG_W_DEF,
    parameter int IDX_W = 4
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        clr,
    input  wire logic                        wr_en,
    input  wire logic [IDX_W-1:0]            wr_idx,
    input  wire logic [TAG_W-1:0]            wr_tag,
    output logic      [DEPTH-1:0]            slot_v,
    output logic      [DEPTH-1:0][TAG_W-1:0] slot_tag
);
    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0][TAG_W-1:0] r_tag;

    // The parallel write lands after the shift so it wins over the shift-in.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_v   <= '0;
            r_tag <= '0;
        end else begin
            r_v   <= {1'b0, r_v[DEPTH-1:1]};
            r_tag <= {{TAG_W{1'b0}}, r_tag[DEPTH-1:1]};
            if (wr_en) begin
                r_v[wr_idx]   <= 1'b1;
                r_tag[wr_idx] <= wr_tag;
            end
        end
    end

    assign slot_v   = r_v;
    assign slot_tag = r_tag;
endmodule
`default_nettype wire

// File: rtl/ex_latency_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ex_latency_tracker
// Description : Tracks multicycle EX ops and returns each tag L cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_latency_tracker
    import ex_latency_tracker_pkg::*;
#(
    parameter int LAT_W        = 4,
    parameter int TAG_W        = TAG_W_DEF,
    parameter int MAX_INFLIGHT = 4,
    parameter int PIPELINED    = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ex_latency_tracker_if.slave bus
);
    localparam int c_MAX_LAT = (1 << LAT_W) - 1;
    localparam int c_EFF_MAX = (PIPELINED != 0) ? MAX_INFLIGHT : 1;
    localparam int c_CNT_W   = clog2(MAX_INFLIGHT + 1);

    logic [c_MAX_LAT-1:0]            w_slot_v;
    logic [c_MAX_LAT-1:0][TAG_W-1:0] w_slot_tag;
    logic [c_MAX_LAT:0]              w_occ;
    logic [LAT_W-1:0]                w_wr_idx;
    logic [c_CNT_W-1:0]              w_pending;
    logic [c_CNT_W-1:0]              r_cnt;
    logic                            w_lat_zero;
    logic                            w_collide;
    logic                            w_cap_ok;
    logic                            w_ready;
    logic                            w_accept;
    logic                            w_track;
    logic                            w_bypass;
    logic                            w_done_v;

    // Top bit pads the MAX_LAT position, which can never hold a completion.
    assign w_occ = {1'b0, w_slot_v};

    always_comb begin
        w_lat_zero = (bus.issue_latency == '0);
        w_collide  = w_occ[bus.issue_latency];
        w_pending  = r_cnt - c_CNT_W'(w_slot_v[0]);
        w_cap_ok   = (w_pending < c_CNT_W'(c_EFF_MAX));
        if (PIPELINED != 0) begin
            w_ready = ~w_collide & (w_lat_zero | w_cap_ok);
        end else begin
            w_ready = (w_slot_v[c_MAX_LAT-1:1] == '0) & (~w_lat_zero | ~w_slot_v[0]);
        end
        w_ready = w_ready & ~bus.flush & ~rst;
    end

    assign w_accept = bus.issue_valid & w_ready;
    assign w_track  = w_accept & ~w_lat_zero;
    assign w_bypass = w_accept & w_lat_zero;
    assign w_done_v = (w_slot_v[0] | w_bypass) & ~bus.flush & ~rst;
    assign w_wr_idx = bus.issue_latency - LAT_W'(1);

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(w_track) - c_CNT_W'(w_slot_v[0]);
        end
    end

    ex_completion_pipe #(
        .DEPTH (c_MAX_LAT),
        .TAG_W (TAG_W),
        .IDX_W (LAT_W)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.flush),
        .wr_en    (w_track),
        .wr_idx   (w_wr_idx),
        .wr_tag   (bus.issue_tag),
        .slot_v   (w_slot_v),
        .slot_tag (w_slot_tag)
    );

    assign bus.issue_ready  = w_ready;
    assign bus.stall        = bus.issue_valid & ~w_ready;
    assign bus.done_valid   = w_done_v;
    assign bus.done_tag     = !w_done_v ? '0 : (w_slot_v[0] ? w_slot_tag[0] : bus.issue_tag);
    assign bus.busy         = |w_slot_v;
    assign bus.inflight_cnt = r_cnt;
endmodule
`default_nettype wire

// File: doc/ex_latency_tracker.md
Name: ex_latency_tracker

Overview:
- Parametrised successor to the EX-stage single-op stall counter.
- Tracks multicycle operations issued to a functional unit (FPU, IMul/IDiv) and returns each op's 4-bit WB tag exactly L cycles after issue, through one writeback port.
- Supports a pipelined mode (several ops in flight, writeback-slot collision avoidance) and a blocking mode (one op at a time, the legacy behaviour).
- The EX stage uses stall to hold the pipe and done_valid/done_tag to drive WB_out.

Parameters:
LAT_W, 4, latency field width; MAX_LAT = 2**LAT_W-1 (15)
TAG_W, 4, width of the tag carried with each op (WB control bits)
MAX_INFLIGHT, 4, maximum tracked ops (latency>=1) in flight; ignored (=1) when PIPELINED=0
PIPELINED, 1, 1 = overlapped issue, 0 = blocking

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
issue_valid  in  1  op presented this cycle
issue_latency  in  LAT_W  cycles until result; 0 = combinational op
issue_tag  in  TAG_W  tag returned on completion
issue_ready  out  1  op accepted this cycle if issue_valid (combinational)
flush  in  1  discard all in-flight ops (exception, e.g. FP divide-by-zero)
done_valid  out  1  an op completes this cycle
done_tag  out  TAG_W  tag of the completing op (0 when done_valid=0)
stall  out  1  issue_valid & ~issue_ready
busy  out  1  any tracked op in flight
inflight_cnt  out  clog2(MAX_INFLIGHT+1)  tracked ops in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- State: slot[0..MAX_LAT-1], each holding a valid bit and a tag. Each edge, slot[i] <= slot[i+1]; slot[MAX_LAT-1] <= empty.
- Accept: accept = issue_valid & issue_ready & ~flush.
  - Accept with L>=1 writes slot[L-1] at that edge (it overrides the shift into slot[L-1]).
  - An op accepted in cycle c therefore gives done_valid=1 and done_tag=its tag in cycle c+L, for one cycle.
- L=0 bypass: done_valid=1 and done_tag=issue_tag in the same cycle. The op is not tracked and not counted.
- done_valid = (slot[0].v | accepted L=0 op) & ~flush.
- Pipelined issue_ready is 1 only when all of the following hold:
  - ~flush.
  - No collision: for L=0, slot[0].v=0; for 1<=L<MAX_LAT, slot[L].v=0; L=MAX_LAT never collides.
  - Capacity, for L>=1: inflight_cnt - slot[0].v < MAX_INFLIGHT. An op retiring this cycle frees its place.
- Blocking issue_ready: ~flush, and slot[1..MAX_LAT-1] all empty, and (L>=1 or slot[0].v=0). Back-to-back issue is therefore allowed in the completion cycle.
- inflight_cnt:
  - +1 on a tracked accept, -1 when slot[0].v leaves.
  - Both in one cycle leaves the count unchanged.
  - Never exceeds MAX_INFLIGHT.
- busy = |slot[*].v.
- flush: clears all slots and inflight_cnt at the next edge. In the flush cycle, issue is ignored, done_valid=0 and issue_ready=0.
- Reset: all slots empty. inflight_cnt=0, busy=0, done_valid=0, done_tag=0, stall=issue_valid (issue_ready=0 while rst=1). A reset in mid-operation drops in-flight ops without emitting done.
- Priority: rst > flush > accept/shift.
- Tags are opaque. Duplicate tags are legal and returned in completion order.

Decomposition:
- Shared header ex_defs.vh holds:
  - per-op latency constants: LAT_FADD=7, LAT_FSUB=7, LAT_FMUL=5, LAT_FDIV=6, LAT_ITOF=6, LAT_FTOI=6, LAT_IMUL=7, LAT_ALU=0;
  - TAG_W default;
  - a clog2 function.
- One natural sub-module, ex_completion_pipe: the slot shift register with parallel write port and per-slot valid readout. Ready, count and flush logic stay in ex_latency_tracker.

Test Plan:
- Reset then single op: rst for 2 cycles; issue L=5, tag=4'hA at cycle 10 -> busy=1 cycles 11-15, done_valid=1 with tag A only at cycle 15, inflight_cnt 1 then 0 at cycle 16.
- Overlap, pipelined: issue L=7 tag 1 at c=0, then L=5 tag 2 at c=1 -> done tag 2 at c=6 and tag 1 at c=7; issue L=6 at c=1 instead -> issue_ready=0 and stall=1 (collision at c=7).
- Capacity: MAX_INFLIGHT=4, four L=15 ops at c=0..3 -> issue_ready=0 for an L=15 op at c=4; an L=0 op at c=4 is accepted and done at c=4.
- Blocking mode (PIPELINED=0): L=6 at c=0 -> stall for an issue at c=1..5; an issue L=3 at c=6 is accepted while tag 1 completes; its done occurs at c=9.
- Flush: ops with L=7 and L=4 in flight; flush at c=3 -> done_valid=0 at c=3, busy=0 and inflight_cnt=0 at c=4, no done at c=4 or c=7.
- Reset mid-operation: L=6 op in flight, rst at c=2 -> no done ever; an issue at c=2 is refused; an issue at c=3 is accepted normally.
